// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the SRAM bridge.
//   SRAM_DW      - SRAM data bus width (16-bit part)
//   sram_state_t - controller FSM state encoding
package sram_ctrl_pkg;

    localparam int SRAM_DW = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO_SU,
        WR_LO_PW,
        WR_HI_SU,
        WR_HI_PW,
        DONE
    } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: bridges a 32-bit word-addressed memory bus to a 16-bit
// asynchronous SRAM. Each word access becomes two half-word SRAM cycles,
// low half first. All SRAM pin outputs come straight from flops.
//
// Ports:
//   clk, rst_n         - system clock, async active-low reset
//   avs_address        - word address (SRAM_AW-1 bits)
//   avs_read/avs_write - requests, held until the DONE cycle
//   avs_writedata      - 32-bit write data
//   avs_byteenable     - byte lanes, bit 0 = [7:0]
//   avs_readdata       - read data, valid while waitrequest is low
//   avs_waitrequest    - low only in the completing cycle
//   sram_addr          - half-word address
//   sram_dq            - bidirectional SRAM data bus
//   sram_ce_n/oe_n/we_n- active-low strobes
//   sram_be_n          - {UB_N, LB_N}
//
// state    | meaning
// IDLE     | waiting for a request, bus parked
// RD_LO    | low half read, oe_n asserted, sample at phase end
// RD_HI    | high half read, sample at phase end
// WR_LO_SU | low half address/data setup, we_n high
// WR_LO_PW | low half write pulse, we_n low
// WR_HI_SU | high half address/data setup, we_n high
// WR_HI_PW | high half write pulse, we_n low
// DONE     | transfer completes, waitrequest low
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SRAM_AW-2:0] avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    input  logic [3:0]         avs_byteenable,
    output logic [31:0]        avs_readdata,
    output logic               avs_waitrequest,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [1:0]         sram_be_n
);

    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES);

    sram_state_t state, state_nxt;
    logic [2:0]  ws_cnt;
    logic        phase_end;

    // Request fields needed after the accept cycle.
    logic [SRAM_AW-2:0] word_q, word_nxt;
    logic [15:0]        wdata_hi_q, wdata_hi_nxt;
    logic [1:0]         ben_hi_q, ben_hi_nxt;

    logic [SRAM_DW-1:0] dq_out, dq_out_nxt;
    logic               dq_oe, dq_oe_nxt;
    logic [SRAM_AW-1:0] addr_nxt;
    logic               ce_nxt, oe_nxt, we_nxt;
    logic [1:0]         be_nxt;
    logic [31:0]        rdata_nxt;

    assign sram_dq         = dq_oe ? dq_out : 'z;
    assign avs_waitrequest = (state != DONE);
    assign phase_end       = (ws_cnt == WS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ws_cnt       <= '0;
            word_q       <= '0;
            wdata_hi_q   <= '0;
            ben_hi_q     <= '0;
            dq_out       <= '0;
            dq_oe        <= 1'b0;
            sram_addr    <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 2'b11;
            avs_readdata <= '0;
        end else begin
            state        <= state_nxt;
            // Cleared on every state entry so each phase times from zero.
            if (state_nxt != state)
                ws_cnt <= '0;
            else if (ws_cnt != 3'd7)
                ws_cnt <= ws_cnt + 3'd1;
            word_q       <= word_nxt;
            wdata_hi_q   <= wdata_hi_nxt;
            ben_hi_q     <= ben_hi_nxt;
            dq_out       <= dq_out_nxt;
            dq_oe        <= dq_oe_nxt;
            sram_addr    <= addr_nxt;
            sram_ce_n    <= ce_nxt;
            sram_oe_n    <= oe_nxt;
            sram_we_n    <= we_nxt;
            sram_be_n    <= be_nxt;
            avs_readdata <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_nxt     = word_q;
        wdata_hi_nxt = wdata_hi_q;
        ben_hi_nxt   = ben_hi_q;
        dq_out_nxt   = dq_out;
        dq_oe_nxt    = dq_oe;
        addr_nxt     = sram_addr;
        ce_nxt       = sram_ce_n;
        oe_nxt       = sram_oe_n;
        we_nxt       = sram_we_n;
        be_nxt       = sram_be_n;
        rdata_nxt    = avs_readdata;

        case (state)
            IDLE: begin
                if (avs_write) begin
                    word_nxt     = avs_address;
                    wdata_hi_nxt = avs_writedata[31:16];
                    ben_hi_nxt   = avs_byteenable[3:2];
                    if (avs_byteenable == 4'h0) begin
                        state_nxt = DONE;
                    end else if (avs_byteenable[1:0] == 2'b00) begin
                        state_nxt  = WR_HI_SU;
                        addr_nxt   = {avs_address, 1'b1};
                        dq_out_nxt = avs_writedata[31:16];
                        be_nxt     = ~avs_byteenable[3:2];
                        dq_oe_nxt  = 1'b1;
                        ce_nxt     = 1'b0;
                        we_nxt     = 1'b1;
                    end else begin
                        state_nxt  = WR_LO_SU;
                        addr_nxt   = {avs_address, 1'b0};
                        dq_out_nxt = avs_writedata[15:0];
                        be_nxt     = ~avs_byteenable[1:0];
                        dq_oe_nxt  = 1'b1;
                        ce_nxt     = 1'b0;
                        we_nxt     = 1'b1;
                    end
                end else if (avs_read) begin
                    state_nxt = RD_LO;
                    word_nxt  = avs_address;
                    addr_nxt  = {avs_address, 1'b0};
                    ce_nxt    = 1'b0;
                    oe_nxt    = 1'b0;
                    be_nxt    = 2'b00;
                end
            end
            RD_LO: begin
                if (phase_end) begin
                    rdata_nxt[15:0] = sram_dq;
                    addr_nxt        = {word_q, 1'b1};
                    state_nxt       = RD_HI;
                end
            end
            RD_HI: begin
                if (phase_end) begin
                    rdata_nxt[31:16] = sram_dq;
                    ce_nxt           = 1'b1;
                    oe_nxt           = 1'b1;
                    be_nxt           = 2'b11;
                    addr_nxt         = '0;
                    state_nxt        = DONE;
                end
            end
            WR_LO_SU: begin
                we_nxt    = 1'b0;
                state_nxt = WR_LO_PW;
            end
            WR_LO_PW: begin
                if (phase_end) begin
                    we_nxt = 1'b1;
                    if (ben_hi_q == 2'b00) begin
                        ce_nxt    = 1'b1;
                        dq_oe_nxt = 1'b0;
                        be_nxt    = 2'b11;
                        addr_nxt  = '0;
                        state_nxt = DONE;
                    end else begin
                        addr_nxt   = {word_q, 1'b1};
                        dq_out_nxt = wdata_hi_q;
                        be_nxt     = ~ben_hi_q;
                        state_nxt  = WR_HI_SU;
                    end
                end
            end
            WR_HI_SU: begin
                we_nxt    = 1'b0;
                state_nxt = WR_HI_PW;
            end
            WR_HI_PW: begin
                if (phase_end) begin
                    we_nxt    = 1'b1;
                    ce_nxt    = 1'b1;
                    dq_oe_nxt = 1'b0;
                    be_nxt    = 2'b11;
                    addr_nxt  = '0;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance 1: WAIT_STATES = 0 ----------------
    logic [16:0] avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]  sram_be_n;

    sram_ctrl #(.SRAM_AW(18), .WAIT_STATES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    // SRAM model: combinational read, write sampled mid-pulse.
    logic [15:0] mem [0:255] = '{default: 16'h0000};
    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'bz;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[0]) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
            if (!sram_be_n[1]) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
        end
    end

    // ---------------- instance 2: WAIT_STATES = 2 ----------------
    logic [16:0] avs2_address = '0;
    logic        avs2_read = 1'b0;
    logic        avs2_write = 1'b0;
    logic [31:0] avs2_writedata = '0;
    logic [3:0]  avs2_byteenable = '0;
    logic [31:0] avs2_readdata;
    logic        avs2_waitrequest;
    logic [17:0] sram2_addr;
    wire  [15:0] sram2_dq;
    logic        sram2_ce_n, sram2_oe_n, sram2_we_n;
    logic [1:0]  sram2_be_n;

    sram_ctrl #(.SRAM_AW(18), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .avs_address(avs2_address), .avs_read(avs2_read), .avs_write(avs2_write),
        .avs_writedata(avs2_writedata), .avs_byteenable(avs2_byteenable),
        .avs_readdata(avs2_readdata), .avs_waitrequest(avs2_waitrequest),
        .sram_addr(sram2_addr), .sram_dq(sram2_dq),
        .sram_ce_n(sram2_ce_n), .sram_oe_n(sram2_oe_n), .sram_we_n(sram2_we_n),
        .sram_be_n(sram2_be_n)
    );

    // Second SRAM returns an address-derived pattern.
    assign sram2_dq = (!sram2_ce_n && !sram2_oe_n) ? (sram2_addr[15:0] ^ 16'h1234) : 16'bz;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          act;
        int          issue;
        logic        chk_be;
        logic [1:0]  be;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor 1: strobe-active cycles, last be_n during we_n low, completion.
    int          act1 = 0;
    logic [1:0]  last_be1 = 2'b11;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            act1 = 0;
        end else begin
            if (!sram_we_n || !sram_oe_n) act1++;
            if (!sram_we_n) last_be1 = sram_be_n;
            if (!avs_waitrequest) begin
                if (q1.size() == 0) begin
                    chk("unexpected_done1", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("readdata", avs_readdata, e.rdata);
                    chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                    chk("strobe_cycles", 32'(act1), 32'(e.act));
                    if (e.chk_be) chk("be_n", 32'(last_be1), 32'(e.be));
                end
                act1 = 0;
            end
        end
    end

    // Monitor 2.
    int act2 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            act2 = 0;
        end else begin
            if (!sram2_we_n || !sram2_oe_n) act2++;
            if (!avs2_waitrequest) begin
                if (q2.size() == 0) begin
                    chk("unexpected_done2", 32'd1, 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("ws2_readdata", avs2_readdata, e.rdata);
                    chk("ws2_latency", 32'(cyc - e.issue), 32'(e.lat));
                    chk("ws2_oe_cycles", 32'(act2), 32'(e.act));
                end
                act2 = 0;
            end
        end
    end

    // Bus protocol: setup one cycle before we_n falls; oe_n never low with dq driven.
    logic        prev_we = 1'b1;
    logic [35:0] prev_bus = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!sram_we_n && prev_we)
                chk("wr_setup", 32'({sram_addr, sram_dq} ^ prev_bus[35:2]), 32'd0);
            if (!sram_we_n && prev_we)
                chk("be_setup", 32'(sram_be_n), 32'(prev_bus[1:0]));
            if (!sram_oe_n)
                chk("oe_vs_dq_oe", 32'(dut.dq_oe), 32'd0);
        end
        prev_we  = sram_we_n;
        prev_bus = {sram_addr, sram_dq, sram_be_n};
    end

    task automatic do_req(input logic rd, input logic wr, input logic [16:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] exp_rd, input int lat, input int act,
                          input logic cb, input logic [1:0] ebe);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = a;
        avs_writedata  = wd;
        avs_byteenable = be;
        e.rdata = exp_rd; e.lat = lat; e.act = act; e.issue = cyc; e.chk_be = cb; e.be = ebe;
        q1.push_back(e);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!avs_waitrequest) break;
        end
        if (n == 50) chk("req_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_be_n", 32'(sram_be_n), 32'd3);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_oe", 32'(dut.dq_oe), 32'd0);
        rst_n = 1'b1;

        // full write, read back
        do_req(0, 1, 17'h10, 32'hDEADBEEF, 4'hF, 32'h0, 5, 2, 1, 2'b00);
        chk("mem20", 32'(mem[8'h20]), 32'hBEEF);
        chk("mem21", 32'(mem[8'h21]), 32'hDEAD);
        do_req(1, 0, 17'h10, 32'h0, 4'hF, 32'hDEADBEEF, 3, 2, 0, 2'b00);
        // high-half only, one byte lane
        do_req(0, 1, 17'h10, 32'h12345678, 4'b0100, 32'hDEADBEEF, 3, 1, 1, 2'b10);
        chk("mem21_part", 32'(mem[8'h21]), 32'hDE34);
        chk("mem20_kept", 32'(mem[8'h20]), 32'hBEEF);
        // no lanes: no SRAM activity
        do_req(0, 1, 17'h10, 32'hFFFFFFFF, 4'h0, 32'hDEADBEEF, 1, 0, 0, 2'b00);
        chk("mem21_be0", 32'(mem[8'h21]), 32'hDE34);
        // low-half only
        do_req(0, 1, 17'h11, 32'hAAAA5555, 4'b0011, 32'hDEADBEEF, 3, 1, 1, 2'b00);
        chk("mem22", 32'(mem[8'h22]), 32'h5555);
        chk("mem23", 32'(mem[8'h23]), 32'h0000);
        // read and write together: write wins
        do_req(1, 1, 17'h20, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF, 5, 2, 1, 2'b00);
        do_req(1, 0, 17'h20, 32'h0, 4'hF, 32'hCAFEF00D, 3, 2, 0, 2'b00);
        do_req(1, 0, 17'h10, 32'h0, 4'h0, 32'hDE34BEEF, 3, 2, 0, 2'b00);

        // reset during the low-half write pulse
        @(posedge clk);
        #1;
        avs_write = 1'b1; avs_address = 17'h30; avs_writedata = 32'h11112222; avs_byteenable = 4'hF;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!sram_we_n) break;
        end
        chk("reach_lo_pw", 32'(n < 20), 32'd1);
        avs_write = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we_n", 32'(sram_we_n), 32'd1);
        chk("arst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("arst_dq_oe", 32'(dut.dq_oe), 32'd0);
        chk("arst_waitrequest", 32'(avs_waitrequest), 32'd1);
        chk("arst_readdata", avs_readdata, 32'h0);
        chk("mem60_partial", 32'(mem[8'h60]), 32'h2222);
        chk("mem61_untouched", 32'(mem[8'h61]), 32'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_req(1, 0, 17'h10, 32'h0, 4'hF, 32'hDE34BEEF, 3, 2, 0, 2'b00);

        // wait states = 2: three-cycle sample phases
        @(posedge clk);
        #1;
        avs2_read = 1'b1; avs2_address = 17'h33;
        e.rdata = 32'h12531252; e.lat = 7; e.act = 6; e.issue = cyc; e.chk_be = 0; e.be = 2'b00;
        q2.push_back(e);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!avs2_waitrequest) break;
        end
        if (n == 50) chk("req2_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        avs2_read = 1'b0;

        repeat (3) @(posedge clk);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
